// File: rtl/viterbi_pkg.sv
// ============================================================================
//  Module      : viterbi_pkg
//  Description : Shared code constants, encoder state encoding and symbol type
//                used by the convolutional encoder and the Viterbi decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

    localparam int          K  = 3;
    // Tap order is {b, s0, s1}; the same labels drive the decoder's branch metrics.
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TAIL0 = 2'd2,
        TAIL1 = 2'd3
    } enc_state_t;

    typedef logic [1:0] sym_t;

endpackage

`default_nettype wire

// File: rtl/conv_enc_branch.sv
// ============================================================================
//  Module      : conv_enc_branch
//  Description : Combinational K=3 branch output: (b, s1, s0) -> {c0, c1}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_enc_branch
    import viterbi_pkg::*;
(
    input  logic b,
    input  logic s1,
    input  logic s0,
    output sym_t sym
);

    logic [K-1:0] w_taps;

    assign w_taps = {b, s0, s1};
    assign sym    = {^(G0 & w_taps), ^(G1 & w_taps)};

endmodule

`default_nettype wire

// File: rtl/conv_encoder.sv
// ============================================================================
//  Module      : conv_encoder
//  Description : Rate-1/2 K=3 convolutional encoder with two zero tail bits
//                per frame; optional [11;10] puncturing via CONV_ENC_PUNCT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int FRAME_MAX = 32,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       in_bit_i,
    input  logic       in_last_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output sym_t       out_sym_o,
    output logic [1:0] out_mask_o,
    output logic       out_tail_o,
    output logic       out_last_o,
    output logic       trunc_o
);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(FRAME_MAX - 1);

    enc_state_t       r_state;
    logic [1:0]       r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    sym_t             r_out_sym;
    logic             r_out_tail;
    logic             r_out_last;
    logic             r_trunc;

    logic w_slot_free;
    logic w_in_phase;
    logic w_accept;
    logic w_bit;
    logic w_at_limit;
    sym_t w_sym;

    assign w_slot_free = !r_out_valid || out_ready_i;
    assign w_in_phase  = (r_state == IDLE) || (r_state == DATA);
    assign in_ready_o  = !rst && w_in_phase && w_slot_free;
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_bit       = w_in_phase ? in_bit_i : 1'b0;
    assign w_at_limit  = (r_cnt == c_last_idx);

    conv_enc_branch u_branch (
        .b   (w_bit),
        .s1  (r_sreg[1]),
        .s0  (r_sreg[0]),
        .sym (w_sym)
    );

`ifdef CONV_ENC_PUNCT_EN
    logic [1:0] r_out_mask;

    // Odd data bits drop c1; tails are always sent in full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_mask <= 2'b11;
        end else if (w_slot_free) begin
            if (w_accept && r_cnt[0])
                r_out_mask <= 2'b10;
            else
                r_out_mask <= 2'b11;
        end
    end

    assign out_mask_o = r_out_mask;
`else
    assign out_mask_o = 2'b11;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sreg      <= 2'b00;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sym   <= 2'b00;
            r_out_tail  <= 1'b0;
            r_out_last  <= 1'b0;
            r_trunc     <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            if (w_slot_free)
                r_out_valid <= 1'b0;

            case (r_state)
                IDLE, DATA: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_sym   <= w_sym;
                        r_out_tail  <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_sreg      <= {r_sreg[0], w_bit};
                        r_cnt       <= r_cnt + CNT_W'(1);
                        if (in_last_i || w_at_limit) begin
                            r_state <= TAIL0;
                            r_trunc <= w_at_limit && !in_last_i;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                TAIL0: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_sym   <= w_sym;
                        r_out_tail  <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_sreg      <= {r_sreg[0], 1'b0};
                        r_state     <= TAIL1;
                    end
                end
                TAIL1: begin
                    // Second zero shifted in: trellis is back in S0.
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_sym   <= w_sym;
                        r_out_tail  <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_sreg      <= 2'b00;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_sym_o   = r_out_sym;
    assign out_tail_o  = r_out_tail;
    assign out_last_o  = r_out_last;
    assign trunc_o     = r_trunc;

endmodule

`default_nettype wire
